// File: rtl/rvm_exec_ctrl_pkg.sv
// Shared codes for the rvm execute sequencer: functional-unit selects,
// PC control encodings and the controller state type.
package rvm_exec_ctrl_pkg;

  localparam logic [1:0] FU_ADD = 2'b00;
  localparam logic [1:0] FU_BIT = 2'b01;
  localparam logic [1:0] FU_SHF = 2'b10;
  localparam logic [1:0] FU_RSV = 2'b11;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_LOAD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_OPND = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4,
    ST_ERR  = 3'd5
  } exec_state_t;

endpackage

// File: rtl/rvm_exec_ctrl.sv
// Multi-cycle execute sequencer: read operands, dispatch to one functional
// unit, wait for its valid (bounded by TIMEOUT), write back and bump the PC.
module rvm_exec_ctrl
  import rvm_exec_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        instr_fu,
  input  logic [1:0]        instr_op,
  input  logic [4:0]        instr_rs1,
  input  logic [4:0]        instr_rs2,
  input  logic [4:0]        instr_rd,
  input  logic [31:0]       instr_imm,
  input  logic              instr_use_imm,
  output logic              s_rs1_en,
  output logic              s_rs2_en,
  output logic [4:0]        s_rs1_addr,
  output logic [4:0]        s_rs2_addr,
  input  logic [31:0]       s_rs1_rdata,
  input  logic [31:0]       s_rs2_rdata,
  output logic [31:0]       fu_lhs,
  output logic [31:0]       fu_rhs,
  output logic [1:0]        f_add_op,
  output logic [1:0]        f_bit_op,
  output logic [1:0]        f_shf_op,
  input  logic              f_add_valid,
  input  logic              f_bit_valid,
  input  logic              f_shf_valid,
  input  logic [32:0]       f_add_result,
  input  logic [31:0]       f_bit_result,
  input  logic [31:0]       f_shf_result,
  output logic              d_rd_wen,
  output logic [4:0]        d_rd_addr,
  output logic [31:0]       d_rd_wdata,
  output logic [1:0]        d_pc_w_en,
  output logic [31:0]       d_pc_wdata,
  output logic              retired,
  output logic              busy,
  output logic              err,
  output exec_state_t       dbg_state
);

  // Handshake: an instruction transfers on a rising edge where instr_valid
  // and instr_ready are both high; instr_ready depends only on the state.

  exec_state_t state;
  logic [1:0]  fu_q, op_q;
  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic [31:0] imm_q, lhs_q, rhs_q, wdata_q;
  logic        use_imm_q;
  logic [7:0]  cnt_q;

  logic        sel_valid;
  logic [31:0] sel_result;
  logic        add_carry_unused;

  assign add_carry_unused = f_add_result[32];

  always_comb begin
    sel_valid  = 1'b0;
    sel_result = 32'd0;
    case (fu_q)
      FU_ADD: begin sel_valid = f_add_valid; sel_result = f_add_result[31:0]; end
      FU_BIT: begin sel_valid = f_bit_valid; sel_result = f_bit_result;       end
      FU_SHF: begin sel_valid = f_shf_valid; sel_result = f_shf_result;       end
      default: begin sel_valid = 1'b0; sel_result = 32'd0; end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      fu_q      <= 2'b00;
      op_q      <= 2'b00;
      rs1_q     <= 5'd0;
      rs2_q     <= 5'd0;
      rd_q      <= 5'd0;
      imm_q     <= 32'd0;
      use_imm_q <= 1'b0;
      lhs_q     <= 32'd0;
      rhs_q     <= 32'd0;
      wdata_q   <= 32'd0;
      cnt_q     <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: if (instr_valid) begin
          fu_q      <= instr_fu;
          op_q      <= instr_op;
          rs1_q     <= instr_rs1;
          rs2_q     <= instr_rs2;
          rd_q      <= instr_rd;
          imm_q     <= instr_imm;
          use_imm_q <= instr_use_imm;
          state     <= (instr_fu == FU_RSV) ? ST_ERR : ST_READ;
        end
        ST_READ: state <= ST_OPND;
        ST_OPND: begin
          lhs_q <= s_rs1_rdata;
          rhs_q <= use_imm_q ? imm_q : s_rs2_rdata;
          cnt_q <= 8'd0;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          cnt_q <= cnt_q + 8'd1;
          // A valid arriving on the last allowed cycle still completes.
          if (sel_valid) begin
            wdata_q <= sel_result;
            state   <= ST_WB;
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            state <= ST_ERR;
          end
        end
        ST_WB:   state <= ST_IDLE;
        ST_ERR:  state <= ST_ERR;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign err         = (state == ST_ERR);
  assign s_rs1_en    = (state == ST_READ);
  assign s_rs2_en    = (state == ST_READ) && !use_imm_q;
  assign s_rs1_addr  = rs1_q;
  assign s_rs2_addr  = rs2_q;
  assign fu_lhs      = lhs_q;
  assign fu_rhs      = rhs_q;
  assign f_add_op    = (state == ST_EXEC && fu_q == FU_ADD) ? op_q : 2'b00;
  assign f_bit_op    = (state == ST_EXEC && fu_q == FU_BIT) ? op_q : 2'b00;
  assign f_shf_op    = (state == ST_EXEC && fu_q == FU_SHF) ? op_q : 2'b00;
  assign d_rd_wen    = (state == ST_WB) && (rd_q != 5'd0);
  assign d_rd_addr   = rd_q;
  assign d_rd_wdata  = wdata_q;
  assign d_pc_w_en   = (state == ST_WB) ? PC_INC : PC_HOLD;
  assign d_pc_wdata  = 32'd0;
  assign retired     = (state == ST_WB);
  assign dbg_state   = state;

endmodule

// File: tb/tb_rvm_exec_ctrl.sv
// Bench for rvm_exec_ctrl: plays the register file and functional units,
// predicts write-back data from an architectural register model.
module tb_rvm_exec_ctrl;
  import rvm_exec_ctrl_pkg::*;

  localparam int TIMEOUT = 4;

  logic clk = 1'b0, reset = 1'b0;
  logic instr_valid = 1'b0, instr_ready;
  logic [1:0] instr_fu = '0, instr_op = '0;
  logic [4:0] instr_rs1 = '0, instr_rs2 = '0, instr_rd = '0;
  logic [31:0] instr_imm = '0;
  logic instr_use_imm = 1'b0;
  logic s_rs1_en, s_rs2_en;
  logic [4:0] s_rs1_addr, s_rs2_addr;
  logic [31:0] s_rs1_rdata = '0, s_rs2_rdata = '0;
  logic [31:0] fu_lhs, fu_rhs;
  logic [1:0] f_add_op, f_bit_op, f_shf_op;
  logic f_add_valid = 1'b0, f_bit_valid = 1'b0, f_shf_valid = 1'b0;
  logic [32:0] f_add_result = '0;
  logic [31:0] f_bit_result = '0, f_shf_result = '0;
  logic d_rd_wen;
  logic [4:0] d_rd_addr;
  logic [31:0] d_rd_wdata, d_pc_wdata;
  logic [1:0] d_pc_w_en;
  logic retired, busy, err;
  exec_state_t dbg_state;

  int n_cmp = 0, n_err = 0;
  logic [31:0] gpr [32];
  logic [31:0] exp_q [$];

  rvm_exec_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_fu(instr_fu), .instr_op(instr_op), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_rd(instr_rd), .instr_imm(instr_imm),
    .instr_use_imm(instr_use_imm),
    .s_rs1_en(s_rs1_en), .s_rs2_en(s_rs2_en),
    .s_rs1_addr(s_rs1_addr), .s_rs2_addr(s_rs2_addr),
    .s_rs1_rdata(s_rs1_rdata), .s_rs2_rdata(s_rs2_rdata),
    .fu_lhs(fu_lhs), .fu_rhs(fu_rhs),
    .f_add_op(f_add_op), .f_bit_op(f_bit_op), .f_shf_op(f_shf_op),
    .f_add_valid(f_add_valid), .f_bit_valid(f_bit_valid), .f_shf_valid(f_shf_valid),
    .f_add_result(f_add_result), .f_bit_result(f_bit_result), .f_shf_result(f_shf_result),
    .d_rd_wen(d_rd_wen), .d_rd_addr(d_rd_addr), .d_rd_wdata(d_rd_wdata),
    .d_pc_w_en(d_pc_w_en), .d_pc_wdata(d_pc_wdata),
    .retired(retired), .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Functional-unit behaviour as seen by the bench (the controller is op-agnostic).
  function automatic logic [32:0] unit_calc(input logic [1:0] fu, input logic [1:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
    case (fu)
      FU_ADD: unit_calc = (op == 2'd1) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      FU_BIT: case (op)
        2'd0: unit_calc = {1'b0, a & b};
        2'd1: unit_calc = {1'b0, a | b};
        2'd2: unit_calc = {1'b0, a ^ b};
        default: unit_calc = {1'b0, a & ~b};
      endcase
      default: case (op)
        2'd1: unit_calc = {1'b0, a >> b[4:0]};
        2'd2: unit_calc = {1'b0, 32'($signed(a) >>> b[4:0])};
        default: unit_calc = {1'b0, a << b[4:0]};
      endcase
    endcase
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    instr_valid = 1'b0;
    {f_add_valid, f_bit_valid, f_shf_valid} = 3'b000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_instr(input logic [1:0] fu, input logic [1:0] op, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm,
                           input logic use_imm, input int delay);
    logic [31:0] rhs, wd, lhs_m;
    logic [32:0] full;
    logic [1:0] eo_add, eo_bit, eo_shf;
    lhs_m = gpr[rs1];
    rhs = use_imm ? imm : gpr[rs2];
    full = unit_calc(fu, op, lhs_m, rhs);
    exp_q.push_back(full[31:0]);
    eo_add = (fu == FU_ADD) ? op : 2'b00;
    eo_bit = (fu == FU_BIT) ? op : 2'b00;
    eo_shf = (fu == FU_SHF) ? op : 2'b00;
    @(negedge clk);
    n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL idle_ready: got %b want 1", instr_ready); end
    instr_fu = fu; instr_op = op; instr_rs1 = rs1; instr_rs2 = rs2; instr_rd = rd;
    instr_imm = imm; instr_use_imm = use_imm; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    {instr_fu, instr_op, instr_rs1, instr_rs2, instr_rd} = 19'($urandom);
    instr_imm = $urandom; instr_use_imm = 1'($urandom);
    @(negedge clk);
    n_cmp++; if ({s_rs1_en, s_rs1_addr, s_rs2_en} !== {1'b1, rs1, !use_imm})
      begin n_err++; $display("FAIL read_ports: got en1=%b a1=%0d en2=%b want 1 %0d %b", s_rs1_en, s_rs1_addr, s_rs2_en, rs1, !use_imm); end
    if (!use_imm) begin
      n_cmp++; if (s_rs2_addr !== rs2) begin n_err++; $display("FAIL rs2_addr: got %0d want %0d", s_rs2_addr, rs2); end
    end
    @(posedge clk); #1;
    s_rs1_rdata = gpr[rs1];
    s_rs2_rdata = use_imm ? $urandom : gpr[rs2];
    @(negedge clk);
    n_cmp++; if ({dbg_state, s_rs1_en, s_rs2_en, retired} !== {ST_OPND, 3'b000})
      begin n_err++; $display("FAIL opnd_cycle: got st=%0d en=%b%b ret=%b want st=%0d 000", dbg_state, s_rs1_en, s_rs2_en, retired, ST_OPND); end
    @(posedge clk);
    for (int k = 0; k <= delay; k++) begin
      @(negedge clk);
      n_cmp++; if ({dbg_state, f_add_op, f_bit_op, f_shf_op, fu_lhs, fu_rhs} !== {ST_EXEC, eo_add, eo_bit, eo_shf, lhs_m, rhs})
        begin n_err++; $display("FAIL exec_k%0d: got st=%0d ops=%b/%b/%b lhs=%h rhs=%h want st=%0d ops=%b/%b/%b lhs=%h rhs=%h",
          k, dbg_state, f_add_op, f_bit_op, f_shf_op, fu_lhs, fu_rhs, ST_EXEC, eo_add, eo_bit, eo_shf, lhs_m, rhs); end
      f_add_result = {1'b1, 32'($urandom)}; f_bit_result = $urandom; f_shf_result = $urandom;
      {f_add_valid, f_bit_valid, f_shf_valid} = 3'($urandom);
      if (k == delay) begin
        full = unit_calc(fu, op, fu_lhs, fu_rhs);
        case (fu)
          FU_ADD: begin f_add_valid = 1'b1; f_add_result = full; end
          FU_BIT: begin f_bit_valid = 1'b1; f_bit_result = full[31:0]; end
          default: begin f_shf_valid = 1'b1; f_shf_result = full[31:0]; end
        endcase
      end else begin
        case (fu)
          FU_ADD: f_add_valid = 1'b0;
          FU_BIT: f_bit_valid = 1'b0;
          default: f_shf_valid = 1'b0;
        endcase
      end
      @(posedge clk); #1;
      {f_add_valid, f_bit_valid, f_shf_valid} = 3'b000;
    end
    @(negedge clk);
    wd = exp_q.pop_front();
    n_cmp++; if ({retired, d_rd_wen, d_rd_addr, d_rd_wdata, d_pc_w_en} !== {1'b1, rd != 5'd0, rd, wd, PC_INC})
      begin n_err++; $display("FAIL writeback: got ret=%b wen=%b rd=%0d wd=%h pc=%b want 1 %b %0d %h 01",
        retired, d_rd_wen, d_rd_addr, d_rd_wdata, d_pc_w_en, rd != 5'd0, rd, wd); end
    if (rd != 5'd0) gpr[rd] = wd;
    @(negedge clk);
    n_cmp++; if ({retired, d_rd_wen, d_pc_w_en, instr_ready, busy} !== 6'b000010)
      begin n_err++; $display("FAIL post_wb: got ret=%b wen=%b pc=%b rdy=%b busy=%b want 0 0 00 1 0",
        retired, d_rd_wen, d_pc_w_en, instr_ready, busy); end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_cmp++; if ({instr_ready, busy, err, retired, d_rd_wen, d_pc_w_en, s_rs1_en, s_rs2_en} !== 9'b100000000)
      begin n_err++; $display("FAIL reset_ctrl: got rdy=%b busy=%b err=%b ret=%b wen=%b pc=%b want 1 0 0 0 0 00",
        instr_ready, busy, err, retired, d_rd_wen, d_pc_w_en); end
    n_cmp++; if ({fu_lhs, fu_rhs, d_rd_wdata, d_pc_wdata, f_add_op, f_bit_op, f_shf_op} !== '0)
      begin n_err++; $display("FAIL reset_data: got lhs=%h rhs=%h wd=%h want 0", fu_lhs, fu_rhs, d_rd_wdata); end
  endtask

  task automatic test_add_basic();
    gpr[1] = 32'd5; gpr[2] = 32'd7;
    run_instr(FU_ADD, 2'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 0);
    n_cmp++; if (gpr[3] !== 32'd12) begin n_err++; $display("FAIL add_model: got %0d want 12", gpr[3]); end
  endtask

  task automatic test_shift_imm();
    gpr[4] = 32'h8000_0000;
    run_instr(FU_SHF, 2'd1, 5'd4, 5'd9, 5'd5, 32'd4, 1'b1, 3);
    n_cmp++; if (gpr[5] !== 32'h0800_0000) begin n_err++; $display("FAIL shf_model: got %h want 08000000", gpr[5]); end
  endtask

  task automatic test_carry_x0();
    gpr[6] = 32'hFFFF_FFFF; gpr[7] = 32'd2;
    run_instr(FU_ADD, 2'd0, 5'd6, 5'd7, 5'd0, 32'd0, 1'b0, 1);
  endtask

  task automatic test_back_to_back();
    gpr[8] = 32'h0000_00F0;
    run_instr(FU_BIT, 2'd1, 5'd8, 5'd0, 5'd10, 32'h0000_000F, 1'b1, 0);
    run_instr(FU_ADD, 2'd0, 5'd10, 5'd10, 5'd11, 32'd0, 1'b0, 2);
    n_cmp++; if (gpr[11] !== 32'h0000_01FE) begin n_err++; $display("FAIL b2b_model: got %h want 000001fe", gpr[11]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_instr(2'($urandom_range(0, 2)), 2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                $urandom, 1'($urandom), $urandom_range(0, TIMEOUT - 1));
  endtask

  task automatic test_reset_mid();
    int bad;
    gpr[12] = 32'd1;
    @(negedge clk);
    instr_fu = FU_ADD; instr_rs1 = 5'd12; instr_rs2 = 5'd12; instr_rd = 5'd13;
    instr_use_imm = 1'b0; instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (dbg_state !== ST_EXEC) begin n_err++; $display("FAIL mid_pre: got st=%0d want %0d", dbg_state, ST_EXEC); end
    f_add_valid = 1'b1; f_add_result = 33'd2;
    reset = 1'b1; #1;
    n_cmp++; if ({instr_ready, busy, d_rd_wen, d_pc_w_en, retired} !== 6'b100000)
      begin n_err++; $display("FAIL mid_reset: got rdy=%b busy=%b wen=%b pc=%b ret=%b want 1 0 0 00 0",
        instr_ready, busy, d_rd_wen, d_pc_w_en, retired); end
    @(negedge clk); reset = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (retired || d_rd_wen || d_pc_w_en != PC_HOLD) bad++;
    end
    f_add_valid = 1'b0;
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL mid_spurious: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_timeout();
    int bad;
    gpr[14] = 32'd3;
    @(negedge clk);
    instr_fu = FU_BIT; instr_op = 2'd2; instr_rs1 = 5'd14; instr_rs2 = 5'd14;
    instr_rd = 5'd15; instr_use_imm = 1'b0; instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    bad = 0;
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge clk);
      f_add_valid = 1'b1; f_shf_valid = 1'b1;
      if (dbg_state != ST_EXEC || err) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL to_wait: got %0d non-EXEC cycles want 0", bad); end
    @(negedge clk);
    n_cmp++; if ({err, busy, instr_ready, d_rd_wen, d_pc_w_en, retired, s_rs1_en} !== 8'b11000000)
      begin n_err++; $display("FAIL to_err: got err=%b busy=%b rdy=%b wen=%b pc=%b ret=%b want 1 1 0 0 00 0",
        err, busy, instr_ready, d_rd_wen, d_pc_w_en, retired); end
    instr_valid = 1'b1; f_bit_valid = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (instr_ready || !err || retired || d_pc_w_en != PC_HOLD) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL to_sticky: got %0d bad cycles want 0", bad); end
    apply_reset();
    @(negedge clk);
    n_cmp++; if ({err, instr_ready, busy} !== 3'b010) begin n_err++; $display("FAIL to_clear: got err=%b rdy=%b busy=%b want 0 1 0", err, instr_ready, busy); end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    instr_fu = FU_RSV; instr_op = 2'd1; instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({err, busy, instr_ready, s_rs1_en, s_rs2_en, d_rd_wen, retired} !== 7'b1100000)
      begin n_err++; $display("FAIL illegal: got err=%b busy=%b rdy=%b en=%b%b want 1 1 0 00", err, busy, instr_ready, s_rs1_en, s_rs2_en); end
    apply_reset();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) gpr[i] = (i == 0) ? 32'd0 : $urandom;
    test_reset();
    test_add_basic();
    test_shift_imm();
    test_carry_x0();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_random();
    test_timeout();
    test_illegal();
    test_add_basic();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
